// File: rtl/iir_out_fifo.sv
// Elastic FWFT output buffer behind iir_filter: absorbs the unthrottled sample strobe,
// re-presents samples as a valid/ready stream, reports fill level and a sticky overflow.
module iir_out_fifo #(
    parameter int NB         = 12,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vIn,
    input  logic [NB-1:0]         dIn,
    input  logic                  rdy,
    output logic                  vOut,
    output logic [NB-1:0]         dOut,
    output logic [LOG2_DEPTH:0]   level,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int                    DEPTH   = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0]   LVL_MAX = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]   LVL_ONE = (LOG2_DEPTH + 1)'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

    logic [NB-1:0]         mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign full = (level == LVL_MAX);
    assign vOut = (level != '0);
    assign dOut = vOut ? mem[rd_ptr] : '0;

    assign pop  = vOut & rdy;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push = vIn & (~full | pop);
    assign drop = vIn & full & ~pop;

    // Storage carries no reset; contents are meaningless while level is 0.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= dIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // Set has priority over clear so a coincident drop is never hidden.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed self-checking bench for iir_out_fifo: reset, pass-through, fill/drain with wrap,
// full push+pop, overflow set/clear priority and mid-stream reset.
module tb_iir_out_fifo;

    localparam int NB         = 12;
    localparam int LOG2_DEPTH = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                vIn;
    logic [NB-1:0]       dIn;
    logic                rdy;
    logic                vOut;
    logic [NB-1:0]       dOut;
    logic [LOG2_DEPTH:0] level;
    logic                ovf;
    logic                ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [NB-1:0] exp_seq [12];
    logic [NB-1:0] exp_800 [8];

    iir_out_fifo #(.NB(NB), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .vIn     (vIn),
        .dIn     (dIn),
        .rdy     (rdy),
        .vOut    (vOut),
        .dOut    (dOut),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [NB-1:0] d,
                             input logic [LOG2_DEPTH:0] lv, input logic o);
        chk({tag, ".vOut"},  32'(vOut),  32'(v));
        chk({tag, ".dOut"},  32'(dOut),  32'(d));
        chk({tag, ".level"}, 32'(level), 32'(lv));
        chk({tag, ".ovf"},   32'(ovf),   32'(o));
    endtask

    initial begin
        exp_seq = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
                    12'h007, 12'h008, 12'h00A, 12'h00B, 12'h00C, 12'h00D};
        exp_800 = '{12'h011, 12'h012, 12'h013, 12'h014, 12'h015, 12'h016,
                    12'h017, 12'h800};

        rst = 1'b1; vIn = 1'b0; dIn = '0; rdy = 1'b1; ovf_clr = 1'b0;

        // Reset / idle
        tick();
        chk_state("rst1", 1'b0, 12'h000, 4'd0, 1'b0);
        tick();
        chk_state("rst2", 1'b0, 12'h000, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_state("idle", 1'b0, 12'h000, 4'd0, 1'b0);

        // Single pass-through with one cycle latency
        vIn = 1'b1; dIn = 12'h7FF;
        tick();
        vIn = 1'b0; dIn = 12'h000;
        chk_state("pass_in", 1'b1, 12'h7FF, 4'd1, 1'b0);
        tick();
        chk_state("pass_out", 1'b0, 12'h000, 4'd0, 1'b0);

        // Fill 0x001..0x008 with sink stalled
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vIn = 1'b1; dIn = NB'(i);
            tick();
        end
        chk_state("full", 1'b1, 12'h001, 4'd8, 1'b0);

        // Push into full buffer is dropped
        dIn = 12'h009;
        tick();
        vIn = 1'b0;
        chk_state("drop", 1'b1, 12'h001, 4'd8, 1'b1);

        // Overflow clear alone, then clear coincident with a drop, then clear again
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(ovf), 32'd0);
        vIn = 1'b1; dIn = 12'h0EE;
        tick();
        chk("ovf_clr_vs_drop", 32'(ovf), 32'd1);
        chk("drop2_level", 32'(level), 32'd8);
        vIn = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(ovf), 32'd0);

        // Drain while pushing 0x00A..0x00D; first four edges are full push+pop
        rdy = 1'b1;
        for (int j = 0; j < 12; j++) begin
            vIn = (j < 4); dIn = NB'(12'h00A + j);
            chk($sformatf("drain%0d", j), 32'(dOut), 32'(exp_seq[j]));
            tick();
            if (j == 3) begin
                chk("fullpp_level", 32'(level), 32'd8);
                chk("fullpp_ovf", 32'(ovf), 32'd0);
            end
        end
        vIn = 1'b0;
        chk_state("drained", 1'b0, 12'h000, 4'd0, 1'b0);

        // Full, simultaneous push of 0x800 and pop; 0x800 comes out last
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vIn = 1'b1; dIn = NB'(12'h010 + i);
            tick();
        end
        rdy = 1'b1; dIn = 12'h800;
        tick();
        vIn = 1'b0;
        chk_state("pp800", 1'b1, 12'h011, 4'd8, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rd800_%0d", j), 32'(dOut), 32'(exp_800[j]));
            tick();
        end
        chk_state("empty800", 1'b0, 12'h000, 4'd0, 1'b0);

        // Reset mid-stream with a sample presented during reset
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vIn = 1'b1; dIn = NB'(12'h021 + i);
            tick();
        end
        chk_state("pre_rst", 1'b1, 12'h021, 4'd5, 1'b0);
        rst = 1'b1; dIn = 12'h3AB;
        tick();
        rst = 1'b0; vIn = 1'b0;
        chk_state("mid_rst", 1'b0, 12'h000, 4'd0, 1'b0);
        tick();
        chk_state("post_rst", 1'b0, 12'h000, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
